// File: rtl/waveform_sequencer_if.sv
// Host/generator-side signal bundle for the waveform playlist sequencer.
// The master drives the table and control inputs; the slave is the sequencer itself.
interface waveform_sequencer_if #(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 8
);
    localparam int IW = $clog2(DEPTH);

    logic               wr_en;
    logic [IW-1:0]      wr_addr;
    logic [2:0]         wr_func;
    logic [DWELL_W-1:0] wr_dwell;
    logic [IW:0]        num_entries;
    logic               loop;
    logic               start;
    logic               stop;
    logic               period_tick;
    logic [2:0]         func;
    logic               wave_en;
    logic [IW-1:0]      cur_idx;
    logic               busy;
    logic               done;

    modport master (
        output wr_en, wr_addr, wr_func, wr_dwell, num_entries, loop, start, stop, period_tick,
        input  func, wave_en, cur_idx, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_func, wr_dwell, num_entries, loop, start, stop, period_tick,
        output func, wave_en, cur_idx, busy, done
    );
endinterface

// File: rtl/waveform_sequencer.sv
// Playlist controller: steps through a (func, dwell) table and switches the generator's
// func select only on period boundaries. One-shot or looped playback, graceful stop.
//
// state    | meaning
// IDLE     | silent (func=111), table writable, waiting for start
// RUN      | playing cur_idx, counting period ticks down to entry expiry
// STOPPING | stop seen; current entry plays out until the next period tick
// DONE     | one-cycle done pulse after one-shot completion, then IDLE
module waveform_sequencer #(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    waveform_sequencer_if.slave   bus
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0]        DEPTH_N   = (IW + 1)'(DEPTH);
    localparam logic [IW:0]        N_ONE     = (IW + 1)'(1);
    localparam logic [IW-1:0]      IDX_ONE   = IW'(1);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
    localparam logic [2:0]         SILENT    = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING, DONE} state_t;

    state_t             state, state_next;
    logic [2:0]         func_q, func_next;
    logic [IW-1:0]      idx_q, idx_next;
    logic [DWELL_W-1:0] dwell_cnt, dwell_next;
    logic [IW:0]        n_q, n_next;
    logic               loop_q, loop_next;
    logic               load;
    logic [IW-1:0]      load_idx;
    logic [IW:0]        last_idx;

    logic [2:0]         func_mem  [DEPTH];
    logic [DWELL_W-1:0] dwell_mem [DEPTH];

    // Table has no reset; writes are locked out while playing.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (state == IDLE || state == DONE)) begin
            func_mem[bus.wr_addr]  <= bus.wr_func;
            dwell_mem[bus.wr_addr] <= bus.wr_dwell;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            func_q    <= SILENT;
            idx_q     <= '0;
            dwell_cnt <= '0;
            n_q       <= '0;
            loop_q    <= 1'b0;
        end else begin
            state     <= state_next;
            func_q    <= func_next;
            idx_q     <= idx_next;
            dwell_cnt <= dwell_next;
            n_q       <= n_next;
            loop_q    <= loop_next;
        end
    end

    assign last_idx = n_q - N_ONE;

    always_comb begin
        state_next = state;
        func_next  = func_q;
        idx_next   = idx_q;
        dwell_next = dwell_cnt;
        n_next     = n_q;
        loop_next  = loop_q;
        load       = 1'b0;
        load_idx   = '0;
        case (state)
            IDLE: begin
                func_next = SILENT;
                if (bus.start) begin
                    n_next    = (bus.num_entries > DEPTH_N) ? DEPTH_N : bus.num_entries;
                    loop_next = bus.loop;
                    if (bus.num_entries == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                        load       = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.period_tick) begin
                    // A coincident stop beats entry expiry, so no done pulse.
                    if (bus.stop) begin
                        state_next = IDLE;
                        func_next  = SILENT;
                    end else if (dwell_cnt == DWELL_ONE) begin
                        if ({1'b0, idx_q} != last_idx) begin
                            load     = 1'b1;
                            load_idx = idx_q + IDX_ONE;
                        end else if (loop_q) begin
                            load = 1'b1;
                        end else begin
                            state_next = DONE;
                            func_next  = SILENT;
                        end
                    end else begin
                        dwell_next = dwell_cnt - DWELL_ONE;
                    end
                end else if (bus.stop) begin
                    state_next = STOPPING;
                end
            end
            STOPPING: begin
                if (bus.period_tick) begin
                    state_next = IDLE;
                    func_next  = SILENT;
                end
            end
            DONE: begin
                state_next = IDLE;
                func_next  = SILENT;
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            idx_next   = load_idx;
            func_next  = func_mem[load_idx];
            dwell_next = dwell_mem[load_idx];
        end
    end

    always_comb begin
        bus.func    = func_q;
        bus.cur_idx = idx_q;
        bus.wave_en = (state == RUN) || (state == STOPPING);
        bus.busy    = (state == RUN) || (state == STOPPING);
        bus.done    = (state == DONE);
    end
endmodule

// File: tb/tb_waveform_sequencer.sv
// Directed bench for waveform_sequencer: one task per feature, inline checks, one summary line.
module tb_waveform_sequencer;
    localparam int DEPTH   = 8;
    localparam int DWELL_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   done_seen = 0;

    waveform_sequencer_if #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) sif ();

    waveform_sequencer #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sif.done) done_seen++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sif.period_tick = 1'b1;
        cyc();
        sif.period_tick = 1'b0;
        cyc();
    endtask

    task automatic wr(input logic [2:0] a, input logic [2:0] f, input logic [7:0] d);
        sif.wr_en = 1'b1; sif.wr_addr = a; sif.wr_func = f; sif.wr_dwell = d;
        cyc();
        sif.wr_en = 1'b0;
    endtask

    task automatic go(input logic [3:0] n, input logic lp);
        sif.num_entries = n; sif.loop = lp; sif.start = 1'b1;
        cyc();
        sif.start = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (sif.func !== 3'b111) begin errors++; $display("FAIL reset_func got=%b exp=111", sif.func); end
        checks++; if (sif.wave_en !== 1'b0 || sif.busy !== 1'b0 || sif.done !== 1'b0)
            begin errors++; $display("FAIL reset_flags got we=%b busy=%b done=%b exp 0", sif.wave_en, sif.busy, sif.done); end
        checks++; if (sif.cur_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", sif.cur_idx); end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_one_shot();
        wr(3'd0, 3'b011, 8'd2);
        wr(3'd1, 3'b000, 8'd1);
        go(4'd2, 1'b0);
        checks++; if (sif.func !== 3'b011 || sif.wave_en !== 1'b1 || sif.busy !== 1'b1)
            begin errors++; $display("FAIL oneshot_start got func=%b we=%b busy=%b exp 011 1 1", sif.func, sif.wave_en, sif.busy); end
        cyc();
        tick();
        checks++; if (sif.func !== 3'b011 || sif.cur_idx !== 3'd0)
            begin errors++; $display("FAIL oneshot_t1 got func=%b idx=%0d exp 011 0", sif.func, sif.cur_idx); end
        tick();
        checks++; if (sif.func !== 3'b000 || sif.cur_idx !== 3'd1)
            begin errors++; $display("FAIL oneshot_t2 got func=%b idx=%0d exp 000 1", sif.func, sif.cur_idx); end
        sif.period_tick = 1'b1;
        cyc();
        sif.period_tick = 1'b0;
        checks++; if (sif.done !== 1'b1 || sif.func !== 3'b111 || sif.wave_en !== 1'b0 || sif.busy !== 1'b0)
            begin errors++; $display("FAIL oneshot_done got done=%b func=%b we=%b busy=%b exp 1 111 0 0", sif.done, sif.func, sif.wave_en, sif.busy); end
        cyc();
        checks++; if (sif.done !== 1'b0 || sif.busy !== 1'b0)
            begin errors++; $display("FAIL oneshot_pulse got done=%b busy=%b exp 0 0", sif.done, sif.busy); end
    endtask

    task automatic test_loop();
        logic [2:0] exp_seq [6];
        int d0;
        exp_seq = '{3'b011, 3'b000, 3'b011, 3'b011, 3'b000, 3'b011};
        d0 = done_seen;
        go(4'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (sif.func !== exp_seq[i] || sif.wave_en !== 1'b1)
                begin errors++; $display("FAIL loop_t%0d got func=%b we=%b exp %b 1", i + 1, sif.func, sif.wave_en, exp_seq[i]); end
        end
        sif.stop = 1'b1;
        cyc();
        sif.stop = 1'b0;
        cyc();
        checks++; if (sif.func !== 3'b011 || sif.busy !== 1'b1)
            begin errors++; $display("FAIL loop_stopping got func=%b busy=%b exp 011 1", sif.func, sif.busy); end
        tick();
        checks++; if (sif.func !== 3'b111 || sif.busy !== 1'b0 || done_seen != d0)
            begin errors++; $display("FAIL loop_end got func=%b busy=%b dones=%0d exp 111 0 0", sif.func, sif.busy, done_seen - d0); end
    endtask

    task automatic test_stop();
        int d0;
        d0 = done_seen;
        go(4'd2, 1'b0);
        sif.stop = 1'b1;
        cyc();
        sif.stop = 1'b0;
        cyc(); cyc();
        checks++; if (sif.func !== 3'b011 || sif.wave_en !== 1'b1)
            begin errors++; $display("FAIL stop_hold got func=%b we=%b exp 011 1", sif.func, sif.wave_en); end
        tick();
        checks++; if (sif.func !== 3'b111 || sif.wave_en !== 1'b0 || sif.busy !== 1'b0 || done_seen != d0)
            begin errors++; $display("FAIL stop_mid got func=%b we=%b busy=%b dones=%0d exp 111 0 0 0", sif.func, sif.wave_en, sif.busy, done_seen - d0); end
        go(4'd2, 1'b0);
        tick(); tick();
        sif.stop = 1'b1; sif.period_tick = 1'b1;
        cyc();
        sif.stop = 1'b0; sif.period_tick = 1'b0;
        checks++; if (sif.done !== 1'b0 || sif.func !== 3'b111 || sif.busy !== 1'b0)
            begin errors++; $display("FAIL stop_final got done=%b func=%b busy=%b exp 0 111 0", sif.done, sif.func, sif.busy); end
        cyc(); cyc();
        checks++; if (done_seen != d0) begin errors++; $display("FAIL stop_nodone got dones=%0d exp 0", done_seen - d0); end
    endtask

    task automatic test_dwell_zero();
        wr(3'd0, 3'b101, 8'd0);
        wr(3'd1, 3'b010, 8'd1);
        go(4'd2, 1'b0);
        for (int i = 0; i < 255; i++) tick();
        checks++; if (sif.func !== 3'b101 || sif.cur_idx !== 3'd0)
            begin errors++; $display("FAIL dwell0_255 got func=%b idx=%0d exp 101 0", sif.func, sif.cur_idx); end
        tick();
        checks++; if (sif.func !== 3'b010 || sif.cur_idx !== 3'd1)
            begin errors++; $display("FAIL dwell0_256 got func=%b idx=%0d exp 010 1", sif.func, sif.cur_idx); end
        tick();
        checks++; if (sif.busy !== 1'b0 || sif.func !== 3'b111)
            begin errors++; $display("FAIL dwell0_end got busy=%b func=%b exp 0 111", sif.busy, sif.func); end
    endtask

    task automatic test_zero_len();
        int we_seen = 0;
        go(4'd0, 1'b0);
        checks++; if (sif.done !== 1'b1 || sif.wave_en !== 1'b0 || sif.busy !== 1'b0)
            begin errors++; $display("FAIL zero_done got done=%b we=%b busy=%b exp 1 0 0", sif.done, sif.wave_en, sif.busy); end
        for (int i = 0; i < 4; i++) begin
            if (sif.wave_en) we_seen++;
            cyc();
        end
        checks++; if (we_seen != 0 || sif.done !== 1'b0)
            begin errors++; $display("FAIL zero_quiet got we_cycles=%0d done=%b exp 0 0", we_seen, sif.done); end
    endtask

    task automatic test_wr_during_run();
        wr(3'd0, 3'b011, 8'd2);
        wr(3'd1, 3'b000, 8'd1);
        go(4'd2, 1'b0);
        wr(3'd1, 3'b110, 8'd5);
        tick(); tick();
        checks++; if (sif.func !== 3'b000 || sif.cur_idx !== 3'd1)
            begin errors++; $display("FAIL wr_locked got func=%b idx=%0d exp 000 1", sif.func, sif.cur_idx); end
        sif.period_tick = 1'b1;
        cyc();
        sif.period_tick = 1'b0;
        checks++; if (sif.done !== 1'b1)
            begin errors++; $display("FAIL wr_locked_done got done=%b exp 1", sif.done); end
        cyc();
    endtask

    task automatic test_reset_mid_run();
        go(4'd2, 1'b0);
        tick();
        #2 rst = 1'b0;
        #1;
        checks++; if (sif.func !== 3'b111 || sif.wave_en !== 1'b0 || sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.cur_idx !== 3'd0)
            begin errors++; $display("FAIL rst_mid got func=%b we=%b busy=%b done=%b idx=%0d exp 111 0 0 0 0", sif.func, sif.wave_en, sif.busy, sif.done, sif.cur_idx); end
        cyc();
        rst = 1'b1;
        cyc();
        wr(3'd0, 3'b100, 8'd1);
        go(4'd1, 1'b0);
        checks++; if (sif.func !== 3'b100 || sif.busy !== 1'b1)
            begin errors++; $display("FAIL rst_write got func=%b busy=%b exp 100 1", sif.func, sif.busy); end
        sif.period_tick = 1'b1;
        cyc();
        sif.period_tick = 1'b0;
        checks++; if (sif.done !== 1'b1) begin errors++; $display("FAIL rst_write_done got done=%b exp 1", sif.done); end
        cyc();
    endtask

    task automatic test_back_to_back();
        sif.num_entries = 4'd1; sif.loop = 1'b0; sif.start = 1'b1;
        cyc();
        checks++; if (sif.func !== 3'b100 || sif.busy !== 1'b1)
            begin errors++; $display("FAIL b2b_run1 got func=%b busy=%b exp 100 1", sif.func, sif.busy); end
        sif.period_tick = 1'b1;
        cyc();
        sif.period_tick = 1'b0;
        checks++; if (sif.done !== 1'b1) begin errors++; $display("FAIL b2b_done got done=%b exp 1", sif.done); end
        cyc();
        checks++; if (sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.func !== 3'b111)
            begin errors++; $display("FAIL b2b_idle got busy=%b done=%b func=%b exp 0 0 111", sif.busy, sif.done, sif.func); end
        cyc();
        sif.start = 1'b0;
        checks++; if (sif.busy !== 1'b1 || sif.func !== 3'b100)
            begin errors++; $display("FAIL b2b_run2 got busy=%b func=%b exp 1 100", sif.busy, sif.func); end
        tick();
        cyc();
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 8; i++) wr(3'(i), 3'(i % 7), 8'd1);
        go(4'd15, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        checks++; if (sif.cur_idx !== 3'd7 || sif.func !== 3'b000)
            begin errors++; $display("FAIL clamp_last got idx=%0d func=%b exp 7 000", sif.cur_idx, sif.func); end
        sif.period_tick = 1'b1;
        cyc();
        sif.period_tick = 1'b0;
        checks++; if (sif.done !== 1'b1) begin errors++; $display("FAIL clamp_done got done=%b exp 1", sif.done); end
        cyc();
    endtask

    initial begin
        sif.wr_en = 1'b0; sif.wr_addr = '0; sif.wr_func = '0; sif.wr_dwell = '0;
        sif.num_entries = '0; sif.loop = 1'b0; sif.start = 1'b0; sif.stop = 1'b0;
        sif.period_tick = 1'b0;
        cyc(); cyc();
        test_reset();
        test_one_shot();
        test_loop();
        test_stop();
        test_dwell_zero();
        test_zero_len();
        test_wr_during_run();
        test_reset_mid_run();
        test_back_to_back();
        test_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=expired exp=finished");
        $fatal(1, "timeout");
    end
endmodule
